// File: rtl/dff_const3_core.sv
// Constant-fill register pipeline: internal stages reset to STAGE_RST and shift in FILL,
// so q shows a DEPTH-1 cycle transient after reset and must survive constant propagation.
module dff_const3_core #(
    parameter int   DEPTH     = 2,
    parameter logic Q_RST     = 1'b1,
    parameter logic STAGE_RST = 1'b0,
    parameter logic FILL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    output logic q
);

    logic [DEPTH-2:0] r_stage;
    logic             r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stage <= {(DEPTH-1){STAGE_RST}};
            r_q     <= Q_RST;
        end else begin
            r_stage[0] <= FILL;
            for (int k = 1; k < DEPTH-1; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            // q differs from its reset value only for the transient, so it stays a real flop
            r_q <= r_stage[DEPTH-2];
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_dff_const3_core.sv
// Bench for dff_const3_core: directed reset sequences plus random reset traffic, checked
// against a model that tracks only the number of edges since the last reset edge.
module tb_dff_const3_core;

    logic clk;
    logic reset;
    logic q2;
    logic q4;

    int checks;
    int fails;
    int n_since;

    dff_const3_core #(.DEPTH(2), .Q_RST(1'b1), .STAGE_RST(1'b0), .FILL(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q2)
    );

    dff_const3_core #(.DEPTH(4), .Q_RST(1'b1), .STAGE_RST(1'b0), .FILL(1'b1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected q for a pipeline of given depth, n edges after the last reset edge
    function automatic logic model_q(input int depth, input int n);
        if (n == 0) return 1'b1;
        return (n >= depth) ? 1'b1 : 1'b0;
    endfunction

    task automatic check_all(input string tag);
        logic e2, e4, e1, o1;
        e2 = model_q(2, n_since);
        e4 = model_q(4, n_since);
        e1 = (n_since == 0) ? 1'b0 : 1'b1;
        o1 = dut.r_stage[0];
        checks++;
        assert (q2 === e2) else begin
            fails++;
            $error("FAIL %s q(D2) observed=%b expected=%b n=%0d", tag, q2, e2, n_since);
        end
        checks++;
        assert (o1 === e1) else begin
            fails++;
            $error("FAIL %s q1(D2) observed=%b expected=%b n=%0d", tag, o1, e1, n_since);
        end
        checks++;
        assert (q4 === e4) else begin
            fails++;
            $error("FAIL %s q(D4) observed=%b expected=%b n=%0d", tag, q4, e4, n_since);
        end
    endtask

    // Called at a negedge: drive reset, take one posedge, check at the next negedge
    task automatic step(input logic r, input string tag);
        reset = r;
        @(posedge clk);
        if (!r) n_since = 0;
        else if (n_since < 1000) n_since++;
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset pulse that starts and ends between edges: the sampled value is 1
    task automatic glitch_step(input string tag);
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        if (n_since < 1000) n_since++;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        n_since = 0;
        reset   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) step(1'b0, "reset_hold");
        for (int i = 0; i < 52; i++) step(1'b1, "release");
        step(1'b0, "pulse_rst");
        for (int i = 0; i < 6; i++) step(1'b1, "after_pulse");
        for (int i = 0; i < 3; i++) glitch_step("glitch");
        step(1'b0, "rst_again");
        for (int i = 0; i < 2; i++) glitch_step("glitch_transient");
        for (int i = 0; i < 4; i++) step(1'b1, "settle");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, "random");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
